// File: rtl/pipe_reg_e_pkg.sv
// Shared pipeline constants for the MIPS core.
// Register, opcode and status encodings used by the D/E stage logic.
package pipe_reg_e_pkg;

    localparam logic [4:0] RNONE = 5'h1F;
    localparam logic [5:0] I_NOP = 6'h00;

    localparam logic [2:0] S_BUB = 3'd0;
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    // A real source register equal to a real destination register.
    function automatic logic src_hits(input logic [4:0] src,
                                      input logic [4:0] dst);
        return (src != RNONE) && (dst != RNONE) && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_reg_e_hazard_ctl.sv
// Load-use interlock and F/D stall generation.
// Purely combinational; shared with the fetch/decode register control.
module hazard_ctl
    import pipe_reg_e_pkg::*;
(
    input  logic [4:0] d_srcA,
    input  logic [4:0] d_srcB,
    input  logic [4:0] E_dstM,
    input  logic       m_stall,
    output logic       load_use,
    output logic       stall_fd
);

    // Decode needs a value that the load in E has not produced yet.
    always_comb begin
        load_use = src_hits(d_srcA, E_dstM) | src_hits(d_srcB, E_dstM);
        stall_fd = load_use | m_stall;
    end

endmodule

// File: rtl/pipe_reg_e.sv
// Decode-to-execute pipeline register with bubble/stall control
// and a saturating count of inserted bubbles.
module pipe_reg_e
    import pipe_reg_e_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       d_icode,
    input  logic [5:0]       d_ifun,
    input  logic [W-1:0]     d_valA,
    input  logic [W-1:0]     d_valB,
    input  logic [W-1:0]     d_imm,
    input  logic [W-1:0]     d_pc,
    input  logic [4:0]       d_srcA,
    input  logic [4:0]       d_srcB,
    input  logic [4:0]       d_dstE,
    input  logic [4:0]       d_dstM,
    input  logic [2:0]       d_stat,
    input  logic             e_mispredict,
    input  logic             m_stall,
    output logic [5:0]       E_icode,
    output logic [5:0]       E_ifun,
    output logic [W-1:0]     E_valA,
    output logic [W-1:0]     E_valB,
    output logic [W-1:0]     E_imm,
    output logic [W-1:0]     E_pc,
    output logic [4:0]       E_srcA,
    output logic [4:0]       E_srcB,
    output logic [4:0]       E_dstE,
    output logic [4:0]       E_dstM,
    output logic [2:0]       E_stat,
    output logic             load_use,
    output logic             stall_fd,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [5:0]       icode_q, icode_d, ifun_q, ifun_d;
    logic [W-1:0]     valA_q, valA_d, valB_q, valB_d;
    logic [W-1:0]     imm_q, imm_d, pc_q, pc_d;
    logic [4:0]       srcA_q, srcA_d, srcB_q, srcB_d;
    logic [4:0]       dstE_q, dstE_d, dstM_q, dstM_d;
    logic [2:0]       stat_q, stat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    hazard_ctl u_hazard_ctl (
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_dstM   (dstM_q),
        .m_stall  (m_stall),
        .load_use (load_use),
        .stall_fd (stall_fd)
    );

    // Select hold, bubble or capture; one counter step per bubble.
    always_comb begin
        icode_d = icode_q;
        ifun_d  = ifun_q;
        valA_d  = valA_q;
        valB_d  = valB_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        srcA_d  = srcA_q;
        srcB_d  = srcB_q;
        dstE_d  = dstE_q;
        dstM_d  = dstM_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        if (m_stall) begin
            cnt_d = cnt_q;
        end else if (e_mispredict || load_use) begin
            icode_d = I_NOP;
            ifun_d  = '0;
            valA_d  = '0;
            valB_d  = '0;
            imm_d   = '0;
            pc_d    = '0;
            srcA_d  = RNONE;
            srcB_d  = RNONE;
            dstE_d  = RNONE;
            dstM_d  = RNONE;
            stat_d  = S_BUB;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            icode_d = d_icode;
            ifun_d  = d_ifun;
            valA_d  = d_valA;
            valB_d  = d_valB;
            imm_d   = d_imm;
            pc_d    = d_pc;
            srcA_d  = d_srcA;
            srcB_d  = d_srcB;
            dstE_d  = d_dstE;
            dstM_d  = d_dstM;
            stat_d  = d_stat;
        end
    end

    // E-stage register bank; reset loads a bubble and clears the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            icode_q <= I_NOP;
            ifun_q  <= '0;
            valA_q  <= '0;
            valB_q  <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            srcA_q  <= RNONE;
            srcB_q  <= RNONE;
            dstE_q  <= RNONE;
            dstM_q  <= RNONE;
            stat_q  <= S_BUB;
            cnt_q   <= '0;
        end else begin
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            valA_q  <= valA_d;
            valB_q  <= valB_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            srcA_q  <= srcA_d;
            srcB_q  <= srcB_d;
            dstE_q  <= dstE_d;
            dstM_q  <= dstM_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign E_icode    = icode_q;
    assign E_ifun     = ifun_q;
    assign E_valA     = valA_q;
    assign E_valB     = valB_q;
    assign E_imm      = imm_q;
    assign E_pc       = pc_q;
    assign E_srcA     = srcA_q;
    assign E_srcB     = srcB_q;
    assign E_dstE     = dstE_q;
    assign E_dstM     = dstM_q;
    assign E_stat     = stat_q;
    assign bubble_cnt = cnt_q;

endmodule
